// File: rtl/mem_wb_skid_register_pkg.sv
// Shared definitions for the MEM/WB two-entry skid register.
// State encoding equals the number of held entries.
package mem_wb_skid_register_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH      = 32;
  localparam int unsigned DEFAULT_REG_INDEX_WIDTH = 5;
  localparam int unsigned DEFAULT_COUNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wb_entry_register.sv
// One MEM/WB entry (control bits, read data, ALU result, destination index).
// Loads on the falling edge when load is high, otherwise holds; async clear.
module mem_wb_entry_register
  import mem_wb_skid_register_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int unsigned REG_INDEX_WIDTH = DEFAULT_REG_INDEX_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       d_reg_write,
  input  logic                       d_mem_to_reg,
  input  logic [DATA_WIDTH-1:0]      d_read_data,
  input  logic [DATA_WIDTH-1:0]      d_alu_result,
  input  logic [REG_INDEX_WIDTH-1:0] d_write_reg_index,
  output logic                       q_reg_write,
  output logic                       q_mem_to_reg,
  output logic [DATA_WIDTH-1:0]      q_read_data,
  output logic [DATA_WIDTH-1:0]      q_alu_result,
  output logic [REG_INDEX_WIDTH-1:0] q_write_reg_index
);

  logic                       reg_write_q,       reg_write_d;
  logic                       mem_to_reg_q,      mem_to_reg_d;
  logic [DATA_WIDTH-1:0]      read_data_q,       read_data_d;
  logic [DATA_WIDTH-1:0]      alu_result_q,      alu_result_d;
  logic [REG_INDEX_WIDTH-1:0] write_reg_index_q, write_reg_index_d;

  always_comb begin
    reg_write_d       = reg_write_q;
    mem_to_reg_d      = mem_to_reg_q;
    read_data_d       = read_data_q;
    alu_result_d      = alu_result_q;
    write_reg_index_d = write_reg_index_q;
    if (load) begin
      reg_write_d       = d_reg_write;
      mem_to_reg_d      = d_mem_to_reg;
      read_data_d       = d_read_data;
      alu_result_d      = d_alu_result;
      write_reg_index_d = d_write_reg_index;
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      reg_write_q       <= 1'b0;
      mem_to_reg_q      <= 1'b0;
      read_data_q       <= '0;
      alu_result_q      <= '0;
      write_reg_index_q <= '0;
    end else begin
      reg_write_q       <= reg_write_d;
      mem_to_reg_q      <= mem_to_reg_d;
      read_data_q       <= read_data_d;
      alu_result_q      <= alu_result_d;
      write_reg_index_q <= write_reg_index_d;
    end
  end

  assign q_reg_write       = reg_write_q;
  assign q_mem_to_reg      = mem_to_reg_q;
  assign q_read_data       = read_data_q;
  assign q_alu_result      = alu_result_q;
  assign q_write_reg_index = write_reg_index_q;

endmodule

// File: rtl/mem_wb_skid_register.sv
// MEM/WB pipeline register with a one-entry skid buffer so in_ready never
// depends combinationally on out_ready; also counts backpressure cycles.
module mem_wb_skid_register
  import mem_wb_skid_register_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int unsigned REG_INDEX_WIDTH = DEFAULT_REG_INDEX_WIDTH,
  parameter int unsigned COUNT_WIDTH     = DEFAULT_COUNT_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       RegWrite,
  input  logic                       MemToReg,
  input  logic [DATA_WIDTH-1:0]      data_memory_read_data,
  input  logic [DATA_WIDTH-1:0]      ALU_result,
  input  logic [REG_INDEX_WIDTH-1:0] write_register_index,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic                       RegWrite_output,
  output logic                       MemtoReg_output,
  output logic [DATA_WIDTH-1:0]      data_memory_read_data_output,
  output logic [DATA_WIDTH-1:0]      ALU_result_output,
  output logic [REG_INDEX_WIDTH-1:0] write_register_index_output,
  output logic [DATA_WIDTH-1:0]      writeback_data,
  output logic                       writeback_enable,
  output logic [1:0]                 occupancy,
  output logic [COUNT_WIDTH-1:0]     stall_cycles
);

  state_e                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   stall_q, stall_d;

  logic accept;
  logic drain;
  logic head_load;
  logic skid_load;
  logic head_from_skid;

  logic                       skid_reg_write;
  logic                       skid_mem_to_reg;
  logic [DATA_WIDTH-1:0]      skid_read_data;
  logic [DATA_WIDTH-1:0]      skid_alu_result;
  logic [REG_INDEX_WIDTH-1:0] skid_write_reg_index;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // State register
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  // Next-state logic; flush overrides any same-edge accept or drain
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (accept && !drain)      state_d = ST_TWO;
        else if (!accept && drain) state_d = ST_EMPTY;
      end
      ST_TWO:   if (drain) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  // Handshake and datapath control, all from registered state
  always_comb begin
    in_ready       = (state_q != ST_TWO);
    out_valid      = (state_q != ST_EMPTY);
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = (state_q == ST_TWO);
    if (!flush) begin
      unique case (state_q)
        ST_EMPTY: head_load = accept;
        ST_ONE: begin
          head_load = accept && drain;
          skid_load = accept && !drain;
        end
        ST_TWO:   head_load = drain;
        default:  head_load = 1'b0;
      endcase
    end
  end

  // Saturating backpressure counter, independent of flush
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && !(&stall_q)) begin
      stall_d = stall_q + COUNT_WIDTH'(1);
    end
  end

  mem_wb_entry_register #(
    .DATA_WIDTH      (DATA_WIDTH),
    .REG_INDEX_WIDTH (REG_INDEX_WIDTH)
  ) u_head (
    .clock             (clock),
    .reset             (reset),
    .load              (head_load),
    .d_reg_write       (head_from_skid ? skid_reg_write       : RegWrite),
    .d_mem_to_reg      (head_from_skid ? skid_mem_to_reg      : MemToReg),
    .d_read_data       (head_from_skid ? skid_read_data       : data_memory_read_data),
    .d_alu_result      (head_from_skid ? skid_alu_result      : ALU_result),
    .d_write_reg_index (head_from_skid ? skid_write_reg_index : write_register_index),
    .q_reg_write       (RegWrite_output),
    .q_mem_to_reg      (MemtoReg_output),
    .q_read_data       (data_memory_read_data_output),
    .q_alu_result      (ALU_result_output),
    .q_write_reg_index (write_register_index_output)
  );

  mem_wb_entry_register #(
    .DATA_WIDTH      (DATA_WIDTH),
    .REG_INDEX_WIDTH (REG_INDEX_WIDTH)
  ) u_skid (
    .clock             (clock),
    .reset             (reset),
    .load              (skid_load),
    .d_reg_write       (RegWrite),
    .d_mem_to_reg      (MemToReg),
    .d_read_data       (data_memory_read_data),
    .d_alu_result      (ALU_result),
    .d_write_reg_index (write_register_index),
    .q_reg_write       (skid_reg_write),
    .q_mem_to_reg      (skid_mem_to_reg),
    .q_read_data       (skid_read_data),
    .q_alu_result      (skid_alu_result),
    .q_write_reg_index (skid_write_reg_index)
  );

  assign writeback_data   = MemtoReg_output ? data_memory_read_data_output : ALU_result_output;
  assign writeback_enable = out_valid && RegWrite_output;
  assign occupancy        = state_q;
  assign stall_cycles     = stall_q;

endmodule

// File: tb/tb_mem_wb_skid_register.sv
// Directed bench for mem_wb_skid_register: vector table plus hand sequences
// for stall saturation, flush and asynchronous reset.
module tb_mem_wb_skid_register;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic        RegWrite, MemToReg;
  logic [31:0] data_memory_read_data, ALU_result;
  logic [4:0]  write_register_index;
  logic        flush, out_ready, out_valid;
  logic        RegWrite_output, MemtoReg_output;
  logic [31:0] data_memory_read_data_output, ALU_result_output;
  logic [4:0]  write_register_index_output;
  logic [31:0] writeback_data;
  logic        writeback_enable;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_wb_skid_register #(
    .DATA_WIDTH      (32),
    .REG_INDEX_WIDTH (5),
    .COUNT_WIDTH     (4)
  ) dut (
    .clock                        (clock),
    .reset                        (reset),
    .in_valid                     (in_valid),
    .in_ready                     (in_ready),
    .RegWrite                     (RegWrite),
    .MemToReg                     (MemToReg),
    .data_memory_read_data        (data_memory_read_data),
    .ALU_result                   (ALU_result),
    .write_register_index         (write_register_index),
    .flush                        (flush),
    .out_ready                    (out_ready),
    .out_valid                    (out_valid),
    .RegWrite_output              (RegWrite_output),
    .MemtoReg_output              (MemtoReg_output),
    .data_memory_read_data_output (data_memory_read_data_output),
    .ALU_result_output            (ALU_result_output),
    .write_register_index_output  (write_register_index_output),
    .writeback_data               (writeback_data),
    .writeback_enable             (writeback_enable),
    .occupancy                    (occupancy),
    .stall_cycles                 (stall_cycles)
  );

  typedef struct {
    logic        iv, rw, m2r;
    logic [31:0] rd, alu;
    logic [4:0]  idx;
    logic        fl, ordy;
    logic        e_ov, e_ir;
    logic [1:0]  e_occ;
    logic [31:0] e_wbd;
    logic        e_wbe;
    logic [4:0]  e_idx;
    logic        chk_data;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // One capture edge; outputs are sampled 1 time unit after it
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic drive(input logic iv, input logic rw, input logic m2r, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] idx, input logic fl, input logic ordy);
    in_valid = iv; RegWrite = rw; MemToReg = m2r; data_memory_read_data = rd;
    ALU_result = alu; write_register_index = idx; flush = fl; out_ready = ordy;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_wb_data", writeback_data, 32'd0);
    chk("rst_wb_enable", 32'(writeback_enable), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    #10 reset = 1'b0;

    //            iv rw m2r rd            alu           idx  fl or   ov ir occ wbd           wbe idx  chk
    vq.push_back('{1, 1, 0, 32'h0,        32'h0000_00AA, 5'd3, 0, 1,  1, 1, 1, 32'h0000_00AA, 1, 5'd3, 1});
    vq.push_back('{0, 0, 0, 32'h0,        32'h0,        5'd0, 0, 1,  0, 1, 0, 32'h0000_00AA, 0, 5'd3, 1});
    vq.push_back('{1, 1, 0, 32'h0,        32'h11,       5'd1, 0, 0,  1, 1, 1, 32'h11,        1, 5'd1, 1});
    vq.push_back('{1, 1, 0, 32'h0,        32'h22,       5'd2, 0, 0,  1, 0, 2, 32'h11,        1, 5'd1, 1});
    vq.push_back('{1, 1, 0, 32'h0,        32'h33,       5'd4, 0, 0,  1, 0, 2, 32'h11,        1, 5'd1, 1});
    vq.push_back('{0, 0, 0, 32'h0,        32'h0,        5'd0, 0, 1,  1, 1, 1, 32'h22,        1, 5'd2, 1});
    vq.push_back('{0, 0, 0, 32'h0,        32'h0,        5'd0, 0, 1,  0, 1, 0, 32'h22,        0, 5'd2, 1});
    vq.push_back('{1, 1, 1, 32'hDEAD_BEEF, 32'h1,       5'd5, 0, 0,  1, 1, 1, 32'hDEAD_BEEF, 1, 5'd5, 1});
    vq.push_back('{1, 0, 0, 32'h0,        32'h7,        5'd6, 0, 1,  1, 1, 1, 32'h7,         0, 5'd6, 1});
    vq.push_back('{1, 1, 0, 32'h0,        32'h44,       5'd7, 0, 0,  1, 0, 2, 32'h7,         0, 5'd6, 1});
    vq.push_back('{1, 1, 0, 32'h0,        32'h55,       5'd8, 1, 0,  0, 1, 0, 32'h0,         0, 5'd0, 0});
    vq.push_back('{0, 0, 0, 32'h0,        32'h0,        5'd0, 0, 1,  0, 1, 0, 32'h0,         0, 5'd0, 0});
    vq.push_back('{1, 1, 0, 32'h0,        32'h66,       5'd9, 0, 0,  1, 1, 1, 32'h66,        1, 5'd9, 1});
    vq.push_back('{1, 1, 0, 32'h0,        32'h77,      5'd10, 1, 0,  0, 1, 0, 32'h0,         0, 5'd0, 0});
    vq.push_back('{0, 0, 0, 32'h0,        32'h0,        5'd0, 0, 1,  0, 1, 0, 32'h0,         0, 5'd0, 0});
    vq.push_back('{1, 1, 0, 32'h0,        32'h88,      5'd11, 0, 1,  1, 1, 1, 32'h88,        1, 5'd11, 1});
    vq.push_back('{0, 0, 0, 32'h0,        32'h0,        5'd0, 0, 1,  0, 1, 0, 32'h88,        0, 5'd11, 1});

    step();
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].iv, vq[i].rw, vq[i].m2r, vq[i].rd, vq[i].alu, vq[i].idx, vq[i].fl, vq[i].ordy);
      step();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vq[i].e_ir));
      chk($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vq[i].e_occ));
      chk($sformatf("v%0d_wb_enable", i), 32'(writeback_enable), 32'(vq[i].e_wbe));
      if (vq[i].chk_data) begin
        chk($sformatf("v%0d_wb_data", i), writeback_data, vq[i].e_wbd);
        chk($sformatf("v%0d_index", i), 32'(write_register_index_output), 32'(vq[i].e_idx));
      end
    end

    // Stall counter saturation at 4 bits
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    drive(1, 1, 0, 32'h0, 32'h99, 5'd12, 0, 0);
    step();
    chk("stall_start_occ", 32'(occupancy), 32'd1);
    chk("stall_start", 32'(stall_cycles), 32'd0);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
    repeat (5) step();
    chk("stall_5", 32'(stall_cycles), 32'd5);
    repeat (15) step();
    chk("stall_20_sat", 32'(stall_cycles), 32'd15);
    step();
    chk("stall_held", 32'(stall_cycles), 32'd15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stall_after_flush", 32'(stall_cycles), 32'd15);
    chk("flush_occ", 32'(occupancy), 32'd0);

    // Asynchronous reset between edges while full
    drive(1, 1, 0, 32'h0, 32'hA1, 5'd1, 0, 0);
    step();
    drive(1, 1, 0, 32'h0, 32'hA2, 5'd2, 0, 0);
    step();
    chk("ar_pre_occ", 32'(occupancy), 32'd2);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_occ", 32'(occupancy), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_wb_data", writeback_data, 32'd0);
    chk("ar_wb_enable", 32'(writeback_enable), 32'd0);
    chk("ar_index", 32'(write_register_index_output), 32'd0);
    chk("ar_stall", 32'(stall_cycles), 32'd0);
    #1 reset = 1'b0;
    drive(1, 1, 0, 32'h0, 32'hB1, 5'd13, 0, 1);
    step();
    chk("post_ar_out_valid", 32'(out_valid), 32'd1);
    chk("post_ar_occ", 32'(occupancy), 32'd1);
    chk("post_ar_wb_data", writeback_data, 32'hB1);
    chk("post_ar_index", 32'(write_register_index_output), 32'd13);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 1);
    step();
    chk("post_ar_drain_occ", 32'(occupancy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_register.md
MEM_WB_SKID_REGISTER -- requirements
Module: mem_wb_skid_register

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of read-data and ALU-result fields.
REQ-002 SHALL have parameter REG_INDEX_WIDTH, default 5, width of the write-register index.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, width of the stall-cycle counter.
REQ-004 clock  input  1  single clock; all state captured on falling edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  MEM stage presents a completed access (cache hit).
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 RegWrite, MemToReg  input  1 each  WB control bits.
REQ-009 data_memory_read_data, ALU_result  input  DATA_WIDTH each  MEM results.
REQ-010 write_register_index  input  REG_INDEX_WIDTH  destination register.
REQ-011 flush  input  1  discard all held entries.
REQ-012 out_ready  input  1  WB/register-file accepts the head entry.
REQ-013 out_valid  output  1  head entry valid.
REQ-014 RegWrite_output, MemtoReg_output, data_memory_read_data_output, ALU_result_output, write_register_index_output  output  1/1/DATA_WIDTH/DATA_WIDTH/REG_INDEX_WIDTH  head entry fields.
REQ-015 writeback_data  output  DATA_WIDTH  MemtoReg_output ? data_memory_read_data_output : ALU_result_output.
REQ-016 writeback_enable  output  1  out_valid AND RegWrite_output.
REQ-017 occupancy  output  2  held entries, 0..2.
REQ-018 stall_cycles  output  COUNT_WIDTH  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-019 SHALL hold two entries: head (drives outputs) and skid; state EMPTY(0), ONE(1), TWO(2) equals occupancy.
REQ-020 in_ready SHALL equal (state != TWO), driven from register state only, no combinational path from out_ready.
REQ-021 Accept = in_valid AND in_ready; drain = out_valid AND out_ready, sampled at the capture edge.
REQ-022 EMPTY: accept -> entry to head, ONE.
REQ-023 ONE: accept and drain -> new entry to head, ONE; accept only -> entry to skid, TWO; drain only -> EMPTY.
REQ-024 TWO: drain -> skid moves to head, ONE; no accept possible.
REQ-025 Order SHALL be strict FIFO; no entry lost or duplicated.
REQ-026 flush SHALL clear state to EMPTY at the edge; a same-edge accept SHALL be discarded; stall_cycles unaffected.
REQ-027 Head field registers SHALL hold value when not updated; contents when out_valid=0 are don't-care to consumers but SHALL NOT X-propagate after reset.
REQ-028 writeback_data and writeback_enable SHALL be combinational from head registers, zero added latency.
REQ-029 Latency input-to-output SHALL be one falling edge when EMPTY.
REQ-030 stall_cycles SHALL saturate at all-ones, never wrap.

Reset
REQ-031 reset SHALL asynchronously force state EMPTY, all head and skid fields 0, stall_cycles 0; hence out_valid=0, in_ready=1, writeback_enable=0, writeback_data=0.
REQ-032 Reset mid-operation SHALL discard held entries; first accept after deassertion behaves as from EMPTY.

Structure
REQ-033 Shared package SHALL hold state encoding constants (EMPTY/ONE/TWO) and default widths 32/5/16.
REQ-034 One sub-module, mem_wb_entry_register, SHALL store one entry with load enable and async reset; instantiated twice (head, skid).

Verification
REQ-035 Reset then in_valid=1, ALU_result=0x0000_00AA, index=3, RegWrite=1, MemToReg=0, out_ready=1 -> after one edge out_valid=1, writeback_data=0xAA, writeback_enable=1, index 3.
REQ-036 out_ready=0, push A (0x11) and B (0x22) -> occupancy=2, in_ready=0; third input ignored; release out_ready -> 0x11 then 0x22 on consecutive edges.
REQ-037 MemToReg=1, read data 0xDEAD_BEEF, ALU 0x1 -> writeback_data=0xDEAD_BEEF; RegWrite=0 -> writeback_enable=0 with out_valid=1.
REQ-038 occupancy=2 plus flush with in_valid=1 -> next edge occupancy=0, out_valid=0, in_ready=1, flushed input never appears.
REQ-039 COUNT_WIDTH=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cycles=15, held.
REQ-040 Assert reset asynchronously between edges with occupancy=2 -> outputs zero immediately, occupancy=0.
